// File: rtl/logic_compare_pipe.sv
// Two-stage valid/ready bitwise-operation datapath with popcount, equality flag and saturating match counter.
// Define LOGIC_COMPARE_PARITY_EN to register an XOR-reduction of the result alongside it.
module logic_compare_pipe #(
    parameter int WIDTH = 8,
    parameter int CNT_W = 16
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [WIDTH-1:0]           a,
    input  logic [WIDTH-1:0]           b,
    input  logic [2:0]                 op,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [WIDTH-1:0]           out,
    output logic [$clog2(WIDTH+1)-1:0] ones,
    output logic                       all_eq,
    output logic [CNT_W-1:0]           match_cnt,
    output logic                       parity
);

    localparam int ONES_W = $clog2(WIDTH + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    typedef enum logic [2:0] {
        OP_AND  = 3'b000,
        OP_OR   = 3'b001,
        OP_XOR  = 3'b010,
        OP_XNOR = 3'b011,
        OP_NAND = 3'b100,
        OP_NOR  = 3'b101,
        OP_PASS = 3'b110,
        OP_NOTA = 3'b111
    } op_e;

    logic [WIDTH-1:0]  op_res;
    logic [WIDTH-1:0]  r1;
    logic              eq1;
    logic              v1;
    logic [ONES_W-1:0] r1_ones;
    logic              s2_load;
    logic              s1_adv;
    logic              accept;

    assign s2_load  = !out_valid || out_ready;
    assign s1_adv   = v1 && s2_load;
    assign in_ready = !v1 || s1_adv;
    assign accept   = in_valid && in_ready;

    always_comb begin
        // NOTE: default assigned before the case so no path leaves op_res unassigned (no latch).
        op_res = '0;
        case (op_e'(op))
            OP_AND:  op_res = a & b;
            OP_OR:   op_res = a | b;
            OP_XOR:  op_res = a ^ b;
            OP_XNOR: op_res = ~(a ^ b);
            OP_NAND: op_res = ~(a & b);
            OP_NOR:  op_res = ~(a | b);
            OP_PASS: op_res = a;
            OP_NOTA: op_res = ~a;
        endcase
    end

    // Popcount is computed from the stage-1 result so stage 2 only registers it.
    always_comb begin
        r1_ones = '0;
        for (int i = 0; i < WIDTH; i++) begin
            r1_ones = r1_ones + ONES_W'(r1[i]);
        end
    end

    // NOTE: all sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            v1  <= 1'b0;
            r1  <= '0;
            eq1 <= 1'b0;
        end else if (accept) begin
            v1  <= 1'b1;
            r1  <= op_res;
            eq1 <= (a == b);
        end else if (s1_adv) begin
            v1 <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            out_valid <= 1'b0;
            out       <= '0;
            ones      <= '0;
            all_eq    <= 1'b0;
        end else if (s2_load) begin
            out_valid <= v1;
            if (v1) begin
                out    <= r1;
                ones   <= r1_ones;
                all_eq <= eq1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            match_cnt <= '0;
        end else if (out_valid && out_ready && all_eq && match_cnt != CNT_MAX) begin
            match_cnt <= match_cnt + CNT_W'(1);
        end
    end

`ifdef LOGIC_COMPARE_PARITY_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            parity <= 1'b0;
        end else if (s2_load && v1) begin
            parity <= ^r1;
        end
    end
`else
    assign parity = 1'b0;
`endif

endmodule

// File: tb/tb_logic_compare_pipe.sv
// Self-checking bench for logic_compare_pipe: directed literal tests plus randomized traffic
// checked every cycle against an in-order transaction queue model.
module tb_logic_compare_pipe;

    logic       clk = 1'b0;
    logic       reset;
    logic       in_valid;
    logic       out_ready;
    logic [7:0] a;
    logic [7:0] b;
    logic [2:0] op;

    logic        in_ready, out_valid, all_eq, parity;
    logic [7:0]  out;
    logic [3:0]  ones;
    logic [15:0] match_cnt;

    logic        in_ready2, out_valid2, all_eq2, parity2;
    logic [7:0]  out2;
    logic [3:0]  ones2;
    logic [1:0]  match_cnt2;

    int n_checks = 0;
    int n_pass   = 0;

    always #5 clk = ~clk;

    logic_compare_pipe #(.WIDTH(8), .CNT_W(16)) dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .op(op), .out_valid(out_valid), .out_ready(out_ready),
        .out(out), .ones(ones), .all_eq(all_eq), .match_cnt(match_cnt), .parity(parity)
    );

    logic_compare_pipe #(.WIDTH(8), .CNT_W(2)) dut_sat (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready2),
        .a(a), .b(b), .op(op), .out_valid(out_valid2), .out_ready(out_ready),
        .out(out2), .ones(ones2), .all_eq(all_eq2), .match_cnt(match_cnt2), .parity(parity2)
    );

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h at %0t", name, got, exp, $time);
    endtask

    function automatic logic [7:0] model_op(input logic [2:0] o, input logic [7:0] x, input logic [7:0] y);
        case (o)
            3'd0: return x & y;
            3'd1: return x | y;
            3'd2: return x ^ y;
            3'd3: return ~(x ^ y);
            3'd4: return ~(x & y);
            3'd5: return ~(x | y);
            3'd6: return x;
            default: return ~x;
        endcase
    endfunction

    // Model: transactions in flight in order; age = clock edges since acceptance.
    typedef struct {
        logic [7:0] res;
        logic       eq;
        int         age;
    } txn_t;

    txn_t q[$];
    int   exp_cnt   = 0;
    int   exp_cnt2  = 0;
    bit   model_live = 0;

    always @(negedge clk) begin
        bit exp_valid;
        bit exp_in_ready;
        exp_valid    = (q.size() > 0) && (q[0].age >= 2);
        exp_in_ready = (q.size() < 2) || (out_ready === 1'b1);
        if (model_live) begin
            check("in_ready", in_ready, exp_in_ready);
            check("out_valid", out_valid, exp_valid);
            check("sat_out_valid", out_valid2, exp_valid);
            check("match_cnt", match_cnt, exp_cnt);
            check("sat_match_cnt", match_cnt2, exp_cnt2);
`ifndef LOGIC_COMPARE_PARITY_EN
            check("parity_tied", parity, 0);
`endif
            if (exp_valid) begin
                check("out", out, q[0].res);
                check("ones", ones, $countones(q[0].res));
                check("all_eq", all_eq, q[0].eq);
`ifdef LOGIC_COMPARE_PARITY_EN
                check("parity", parity, ^q[0].res);
`endif
            end
        end
        if (reset) begin
            q.delete();
            exp_cnt    = 0;
            exp_cnt2   = 0;
            model_live = 1;
        end else if (model_live) begin
            if (exp_valid && out_ready) begin
                if (q[0].eq) begin
                    if (exp_cnt < 65535) exp_cnt++;
                    if (exp_cnt2 < 3) exp_cnt2++;
                end
                void'(q.pop_front());
            end
            for (int i = 0; i < q.size(); i++) q[i].age = q[i].age + 1;
            if (in_valid && exp_in_ready)
                q.push_back('{res: model_op(op, a, b), eq: (a == b), age: 1});
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    logic [7:0] ops_exp [8];
    logic [1:0] sat_exp [5];

    initial begin
        ops_exp = '{8'h30, 8'hFC, 8'hCC, 8'h33, 8'hCF, 8'h03, 8'hF0, 8'h0F};
        sat_exp = '{2'd1, 2'd2, 2'd3, 2'd3, 2'd3};

        reset = 1'b1; in_valid = 1'b1; out_ready = 1'b1; a = 8'h5A; b = 8'h5A; op = 3'd0;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0; in_valid = 1'b0;
        @(negedge clk);
        check("rst_out_valid", out_valid, 0);
        check("rst_match_cnt", match_cnt, 0);
        check("rst_in_ready", in_ready, 1);
        check("rst_out", out, 0);
        check("rst_ones", ones, 0);
        check("rst_all_eq", all_eq, 0);
        check("rst_parity", parity, 0);

        // XNOR of equal operands
        cyc(); in_valid = 1'b1; op = 3'b011; a = 8'hA5; b = 8'hA5;
        cyc(); in_valid = 1'b0;
        cyc(); @(negedge clk);
        check("xnor_valid", out_valid, 1);
        check("xnor_out", out, 8'hFF);
        check("xnor_ones", ones, 8);
        check("xnor_all_eq", all_eq, 1);
        cyc(); @(negedge clk);
        check("xnor_match_cnt", match_cnt, 1);

        // All eight ops back-to-back
        for (int k = 0; k < 10; k++) begin
            cyc();
            if (k < 8) begin
                in_valid = 1'b1; op = 3'(k); a = 8'hF0; b = 8'h3C;
            end else begin
                in_valid = 1'b0;
            end
            @(negedge clk);
            if (k >= 2) begin
                check("ops_valid", out_valid, 1);
                check("ops_out", out, ops_exp[k-2]);
                check("ops_all_eq", all_eq, 0);
                check("ops_parity", parity, 0);
                check("ops_match_cnt", match_cnt, 1);
            end
        end

        // Back-pressure: three offers with out_ready low
        cyc(); in_valid = 1'b0; out_ready = 1'b1;
        cyc(); out_ready = 1'b0; in_valid = 1'b1; op = 3'b110; b = 8'h00; a = 8'h11;
        @(negedge clk); check("bp_rdy0", in_ready, 1);
        cyc(); a = 8'h22;
        @(negedge clk); check("bp_rdy1", in_ready, 1);
        for (int k = 0; k < 3; k++) begin
            cyc(); a = 8'h33;
            @(negedge clk);
            check("bp_rdy2", in_ready, 0);
            check("bp_hold_valid", out_valid, 1);
            check("bp_hold_out", out, 8'h11);
        end
        cyc(); out_ready = 1'b1;
        @(negedge clk); check("bp_rel_rdy", in_ready, 1); check("bp_out0", out, 8'h11);
        cyc(); in_valid = 1'b0;
        @(negedge clk); check("bp_v1", out_valid, 1); check("bp_out1", out, 8'h22);
        cyc();
        @(negedge clk); check("bp_v2", out_valid, 1); check("bp_out2", out, 8'h33);
        cyc();
        @(negedge clk); check("bp_drained", out_valid, 0);

        // Reset with both stages full
        cyc(); out_ready = 1'b0; in_valid = 1'b1; op = 3'b110; b = 8'h00; a = 8'hAA;
        cyc(); a = 8'hBB;
        cyc(); in_valid = 1'b0; reset = 1'b1;
        @(negedge clk); check("mid_full_out", out, 8'hAA);
        cyc(); reset = 1'b0; out_ready = 1'b1;
        @(negedge clk);
        check("mid_rst_valid", out_valid, 0);
        check("mid_rst_out", out, 0);
        check("mid_rst_rdy", in_ready, 1);
        check("mid_rst_cnt", match_cnt, 0);
        for (int k = 0; k < 3; k++) begin
            cyc(); @(negedge clk);
            check("mid_no_ghost", out_valid, 0);
        end

        // Saturation on the CNT_W=2 instance
        for (int k = 0; k < 8; k++) begin
            cyc();
            if (k < 5) begin
                in_valid = 1'b1; op = 3'd0; a = 8'h00; b = 8'h00;
            end else begin
                in_valid = 1'b0;
            end
            @(negedge clk);
            if (k >= 3) begin
                check("sat_seq", match_cnt2, sat_exp[k-3]);
                check("sat_wide_cnt", match_cnt, k - 2);
            end
        end

        // Randomized traffic checked by the model
        for (int k = 0; k < 3000; k++) begin
            cyc();
            in_valid  = ($urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 3) != 0);
            op        = 3'($urandom);
            a         = 8'($urandom);
            b         = ($urandom_range(0, 2) == 0) ? a : 8'($urandom);
            if ($urandom_range(0, 199) == 0) reset = 1'b1;
            else reset = 1'b0;
        end
        cyc(); reset = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        repeat (5) cyc();
        @(negedge clk);
        check("final_drained", out_valid, 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
